// File: rtl/button_capture.sv
// button_capture: debounced push-button input port with edge capture,
// interrupt mask and a small memory-mapped register interface.
//
// Parameters
//   WIDTH           number of button inputs
//   DEBOUNCE_CYCLES stable clocks required before an input change is accepted (>= 2)
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any edge
//   IDLE_LEVEL      released level of every input (0 or 1)
//
// Ports
//   clk         system clock
//   reset       synchronous active-high reset
//   address     register select (0 state, 1 mask, 2 reserved, 3 edge capture)
//   chipselect  slave access qualifier
//   write_n     active-low write strobe, valid with chipselect
//   writedata   write data
//   in_port     raw asynchronous button levels
//   readdata    registered read data (one clock latency)
//   irq         level interrupt: any masked capture bit set
module button_capture #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_V   = (IDLE_LEVEL != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] capture;

    logic             wr_en;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_mux;

    assign wr_en = chipselect && !write_n;

    // Edge qualification on the debounced state versus its one-clock delayed copy.
    always_comb begin
        edge_hit = '0;
        if (EDGE_TYPE == 0) begin
            edge_hit = stable & ~stable_d;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = ~stable & stable_d;
        end else begin
            edge_hit = stable ^ stable_d;
        end
    end

    always_comb begin
        clr = '0;
        if (wr_en && address == 2'd3) begin
            clr = writedata;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = stable;
            2'd1:    rd_mux = mask;
            2'd3:    rd_mux = capture;
            default: rd_mux = '0;
        endcase
    end

    // Synchronizer and per-bit debounce. The counter only runs while the
    // synchronized level disagrees with the accepted level; on the final
    // count the new level is committed and the counter restarts from zero,
    // so a transition arriving on that same clock begins a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= IDLE_V;
            sync2    <= IDLE_V;
            stable   <= IDLE_V;
            stable_d <= IDLE_V;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= in_port;
            sync2    <= sync1;
            stable_d <= stable;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Register file. A capture set overrides a write-1-to-clear on the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            capture  <= '0;
            readdata <= '0;
        end else begin
            if (wr_en && address == 2'd1) begin
                mask <= writedata;
            end
            capture  <= (capture & ~clr) | edge_hit;
            readdata <= rd_mux;
        end
    end

    assign irq = |(capture & mask);

endmodule

// File: doc/button_capture.md
BUTTON_CAPTURE -- requirements
Module: button_capture

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: reset is sampled only on the rising edge of clk.
REQ-002 Parameter WIDTH SHALL default to 5 and set the number of button inputs.
REQ-003 Parameter DEBOUNCE_CYCLES SHALL default to 50000 and set the number of stable clocks required before an input change is accepted (minimum 2).
REQ-004 Parameter EDGE_TYPE SHALL default to 1: 0 = rising, 1 = falling, 2 = any edge.
REQ-005 Parameter IDLE_LEVEL SHALL default to 1 and set the released level of every input.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 address  input  2  register select.
REQ-009 chipselect  input  1  slave access qualifier.
REQ-010 write_n  input  1  active-low write strobe, valid with chipselect.
REQ-011 writedata  input  WIDTH  write data.
REQ-012 in_port  input  WIDTH  raw asynchronous button levels.
REQ-013 readdata  output  WIDTH  registered read data.
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 Each in_port bit SHALL pass through a two-flop synchronizer before any other use.
REQ-016 Each bit SHALL have a debounce counter of width clog2(DEBOUNCE_CYCLES) and a stable state bit.
REQ-017 While the synchronized bit equals the stable bit, its counter SHALL be held at 0.
REQ-018 While the synchronized bit differs from the stable bit, its counter SHALL increment once per clock.
REQ-019 When the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, the stable bit SHALL take the synchronized value and the counter SHALL return to 0 on the same clock.
REQ-020 Any return of the synchronized bit to the stable value before acceptance SHALL clear the counter; no stable change occurs.
REQ-021 The edge detector SHALL compare the stable bits with a one-clock-delayed copy and flag edges per EDGE_TYPE.
REQ-022 Edge-capture bit n SHALL set on the clock after a qualifying stable edge on bit n and stay set until cleared.
REQ-023 Register map:
- addr 0: stable state (read-only).
- addr 1: interrupt mask (read/write).
- addr 2: reads 0, writes ignored.
- addr 3: edge capture (read; write-1-to-clear per bit).
REQ-024 A write SHALL occur when chipselect=1 and write_n=0; it takes effect on that clock edge.
REQ-025 If a capture set and a write-1-to-clear hit the same bit on the same clock, the set SHALL win.
REQ-026 readdata SHALL be registered every clock from the mux selected by address, giving one clock of read latency regardless of chipselect.
REQ-027 irq SHALL equal the OR-reduction of (edge capture AND mask), decoded from registers with no added latency.
REQ-028 A debounce acceptance that completes on the same clock as a new raw transition SHALL still commit; the new transition starts a fresh count.

Reset
REQ-029 On reset, the following SHALL load as listed:
- synchronizer flops, stable bits and delayed copies: IDLE_LEVEL on every bit.
- counters, mask, edge capture and readdata: 0.
- irq: 0.
REQ-030 Reset asserted mid-count SHALL abort the count, and no edge SHALL be generated by the reset transition itself.

Verification (WIDTH=5, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=1)
REQ-031 Release reset with in_port=5'h1F, read addr 0 -> readdata=5'h1F one clock after address presented; irq=0.
REQ-032 Drive in_port bit 2 low and hold it -> stable bit 2 clears 2+4 clocks later, edge capture reads 5'h04, and irq stays 0 while the mask is 0.
REQ-033 Write mask 5'h04, then write 5'h04 to addr 3 -> irq rises with the mask write and falls after the clear; capture reads 0.
REQ-034 Pulse bit 0 low for 2 clocks only -> no stable change, capture stays 0, and the counter returns to 0.
REQ-035 Time a write-1-to-clear of bit 1 to coincide with a new falling edge on bit 1 -> capture bit 1 remains 1.
REQ-036 Assert reset with capture=5'h1F, mask=5'h1F and irq=1 -> after one clock, all registers, readdata and irq read 0.
